// File: rtl/popcount_seq_ctrl_if.sv
// Handshake bundle for popcount_seq_ctrl: word-in and count-out valid/ready channels.
// The threshold/over_thresh pair exists only when POPCNT_THRESH_EN is defined.
interface popcount_seq_ctrl_if #(
    parameter int WIDTH = 60
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_count;
    logic             busy;
`ifdef POPCNT_THRESH_EN
    logic [CW-1:0]    threshold;
    logic             over_thresh;

    modport master (
        output in_valid, in_data, out_ready, threshold,
        input  in_ready, out_valid, out_count, busy, over_thresh
    );
    modport slave (
        input  in_valid, in_data, out_ready, threshold,
        output in_ready, out_valid, out_count, busy, over_thresh
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_count, busy
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_count, busy
    );
`endif
endinterface

// File: rtl/popcount_seq_ctrl.sv
// Sequential population counter: one shared 15-bit ones-counter walks the latched word
// slice by slice. Optional count-versus-threshold flag under macro POPCNT_THRESH_EN.
module popcount_seq_ctrl #(
    parameter int WIDTH = 60
) (
    input logic                clk,
    input logic                rst,
    popcount_seq_ctrl_if.slave bus
);
    localparam int SLICES = (WIDTH + 14) / 15;
    localparam int CW     = $clog2(WIDTH + 1);
    localparam int PADW   = SLICES * 15;
    localparam int IW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(SLICES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q;
    logic [PADW-1:0] data_q;
    logic [IW-1:0]   idx_q;
    logic [CW-1:0]   acc_q;
    logic [CW-1:0]   out_count_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;
`ifdef POPCNT_THRESH_EN
    logic [CW-1:0]   thresh_q;
    logic            over_thresh_q;
`endif

    logic [14:0]     slice_d;
    logic [CW-1:0]   acc_d;

    function automatic logic [3:0] ones15(input logic [14:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int k = 0; k < 15; k++) begin
            n = n + {3'b000, v[k]};
        end
        return n;
    endfunction

    // Select the active slice and form the running sum; the sum never exceeds WIDTH.
    always_comb begin
        slice_d = 15'd0;
        for (int s = 0; s < SLICES; s++) begin
            slice_d = (idx_q == IW'(s)) ? data_q[s*15 +: 15] : slice_d;
        end
        acc_d = acc_q + CW'(ones15(slice_d));
    end

    // Controller FSM with all outputs held in registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            data_q        <= '0;
            idx_q         <= '0;
            acc_q         <= '0;
            out_count_q   <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
`ifdef POPCNT_THRESH_EN
            thresh_q      <= '0;
            over_thresh_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        data_q     <= PADW'(bus.in_data);
                        acc_q      <= '0;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= COUNT;
`ifdef POPCNT_THRESH_EN
                        thresh_q   <= bus.threshold;
`endif
                    end
                end
                COUNT: begin
                    acc_q <= acc_d;
                    if (idx_q == LAST_IDX) begin
                        out_count_q   <= acc_d;
                        out_valid_q   <= 1'b1;
                        state_q       <= DONE;
`ifdef POPCNT_THRESH_EN
                        over_thresh_q <= (acc_d >= thresh_q);
`endif
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                DONE: begin
                    // in_ready rises only after this edge, so a word can never ride the consume cycle.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_count   = out_count_q;
    assign bus.busy        = busy_q;
`ifdef POPCNT_THRESH_EN
    assign bus.over_thresh = over_thresh_q;
`endif

endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// Directed bench for popcount_seq_ctrl at WIDTH=60 and WIDTH=20; threshold checks
// are active when POPCNT_THRESH_EN is defined.
module tb_popcount_seq_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    popcount_seq_ctrl_if #(.WIDTH(60)) bus60 ();
    popcount_seq_ctrl_if #(.WIDTH(20)) bus20 ();

    popcount_seq_ctrl #(.WIDTH(60)) dut60 (.clk(clk), .rst(rst), .bus(bus60));
    popcount_seq_ctrl #(.WIDTH(20)) dut20 (.clk(clk), .rst(rst), .bus(bus20));

    typedef struct {
        logic [59:0] data;
        logic [5:0]  exp_cnt;
        logic [5:0]  thr;
        logic        exp_over;
        string       name;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run60(input logic [59:0] data, input logic [5:0] exp_cnt,
                         input logic [5:0] thr, input logic exp_over, input string name);
        int w;
        int lat;
        w = 0;
        while (!bus60.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({name, " in_ready"}, 64'(bus60.in_ready), 64'd1);
        bus60.in_valid = 1'b1;
        bus60.in_data  = data;
`ifdef POPCNT_THRESH_EN
        bus60.threshold = thr;
`endif
        @(negedge clk);
        check({name, " busy"}, 64'(bus60.busy), 64'd1);
        check({name, " in_ready_low"}, 64'(bus60.in_ready), 64'd0);
        bus60.in_valid = 1'b0;
        bus60.in_data  = ~data;
`ifdef POPCNT_THRESH_EN
        bus60.threshold = ~thr;
`endif
        lat = 0;
        while (!bus60.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'd4);
        check({name, " count"}, 64'(bus60.out_count), 64'(exp_cnt));
`ifdef POPCNT_THRESH_EN
        check({name, " over"}, 64'(bus60.over_thresh), 64'(exp_over));
`endif
        bus60.out_ready = 1'b1;
        @(negedge clk);
        bus60.out_ready = 1'b0;
        check({name, " valid_drop"}, 64'(bus60.out_valid), 64'd0);
        check({name, " idle"}, 64'(bus60.in_ready), 64'd1);
    endtask

    task automatic run20(input logic [19:0] data, input logic [4:0] exp_cnt,
                         input logic [4:0] thr, input logic exp_over, input string name);
        int lat;
        bus20.in_valid = 1'b1;
        bus20.in_data  = data;
`ifdef POPCNT_THRESH_EN
        bus20.threshold = thr;
`endif
        @(negedge clk);
        bus20.in_valid = 1'b0;
        bus20.in_data  = ~data;
        lat = 0;
        while (!bus20.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'd2);
        check({name, " count"}, 64'(bus20.out_count), 64'(exp_cnt));
`ifdef POPCNT_THRESH_EN
        check({name, " over"}, 64'(bus20.over_thresh), 64'(exp_over));
`endif
        bus20.out_ready = 1'b1;
        @(negedge clk);
        bus20.out_ready = 1'b0;
        check({name, " idle"}, 64'(bus20.in_ready), 64'd1);
    endtask

    initial begin
        int seen;
        vecs[0] = '{60'h000_0000_0000_0000, 6'd0,  6'd0,  1'b1, "zero"};
        vecs[1] = '{60'hFFF_FFFF_FFFF_FFFF, 6'd60, 6'd60, 1'b1, "ones"};
        vecs[2] = '{60'h555_5555_5555_5555, 6'd30, 6'd31, 1'b0, "alt5"};
        vecs[3] = '{60'h800_0000_0000_0000, 6'd1,  6'd1,  1'b1, "msb"};
        vecs[4] = '{60'h000_0000_0000_7FFF, 6'd15, 6'd16, 1'b0, "slice0"};
        vecs[5] = '{60'h000_0000_0000_8000, 6'd1,  6'd2,  1'b0, "bit15"};
        vecs[6] = '{60'h0FF_0000_0000_00FF, 6'd16, 6'd16, 1'b1, "ends"};
        vecs[7] = '{60'hAAA_AAAA_AAAA_AAAA, 6'd30, 6'd0,  1'b1, "altA"};

        rst = 1'b1;
        bus60.in_valid = 1'b0; bus60.in_data = '0; bus60.out_ready = 1'b0;
        bus20.in_valid = 1'b0; bus20.in_data = '0; bus20.out_ready = 1'b0;
`ifdef POPCNT_THRESH_EN
        bus60.threshold = '0;
        bus20.threshold = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst in_ready", 64'(bus60.in_ready), 64'd1);
        check("rst out_valid", 64'(bus60.out_valid), 64'd0);
        check("rst busy", 64'(bus60.busy), 64'd0);
        check("rst out_count", 64'(bus60.out_count), 64'd0);
        check("rst20 in_ready", 64'(bus20.in_ready), 64'd1);
`ifdef POPCNT_THRESH_EN
        check("rst over", 64'(bus60.over_thresh), 64'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run60(vecs[i].data, vecs[i].exp_cnt, vecs[i].thr, vecs[i].exp_over, vecs[i].name);
        end

        // Consumer stall: result must hold and new words must be refused.
        bus60.in_valid = 1'b1;
        bus60.in_data  = 60'hFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        bus60.in_data  = 60'h0;
        seen = 0;
        while (!bus60.out_valid && seen < 20) begin
            @(negedge clk);
            seen++;
        end
        check("stall latency", 64'(seen), 64'd4);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall valid", 64'(bus60.out_valid), 64'd1);
            check("stall count", 64'(bus60.out_count), 64'd60);
            check("stall in_ready", 64'(bus60.in_ready), 64'd0);
        end
        bus60.out_ready = 1'b1;
        @(negedge clk);
        bus60.out_ready = 1'b0;
        check("release valid", 64'(bus60.out_valid), 64'd0);
        check("release in_ready", 64'(bus60.in_ready), 64'd1);
        check("release busy", 64'(bus60.busy), 64'd0);
        bus60.in_valid = 1'b0;
        @(negedge clk);
        check("no accept", 64'(bus60.busy), 64'd0);

        // Reset during the second COUNT cycle discards the word.
        bus60.in_valid = 1'b1;
        bus60.in_data  = 60'hFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        bus60.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid rst in_ready", 64'(bus60.in_ready), 64'd1);
        check("mid rst busy", 64'(bus60.busy), 64'd0);
        check("mid rst out_count", 64'(bus60.out_count), 64'd0);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus60.out_valid) seen++;
        end
        check("mid rst no valid", 64'(seen), 64'd0);
        run60(60'h123_4567_89AB_CDEF, 6'd32, 6'd33, 1'b0, "post rst");

        run20(20'hFFFFF, 5'd20, 5'd20, 1'b1, "w20 ones t20");
        run20(20'hFFFFF, 5'd20, 5'd21, 1'b0, "w20 ones t21");
        run20(20'h80000, 5'd1,  5'd0,  1'b1, "w20 msb");
        run20(20'h07FFF, 5'd15, 5'd16, 1'b0, "w20 slice0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
